frame_parser: RTL and testbench

- Receive-side counterpart of the 64-bit valid/last frame source in the XDMA DDR data path.
- Accepts streamed command frames: header word, command word, optional body words, tail word.
- Checks each framing field and extracts the command code and 48-bit argument.
- Reports one result per frame (command or error) to the downstream command/DMA control logic. Counts good and bad frames.

---
 rtl/frame_pkg.sv | 17 +
 rtl/frame_parser.sv | 121 ++++++++++++
 tb/tb_frame_parser.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Framing constants, error codes and parser states shared by the
// frame source and the frame parser.
package frame_pkg;

   localparam logic [63:0] HDR_WORD = 64'hFF00_5A5A_55AA_0F0F;
   localparam logic [47:0] CMD_TAG  = 48'hBCBC_4400_0004;
   localparam logic [15:0] TAIL_TAG = 16'hFCFC;

   localparam logic [2:0] ERR_HDR   = 3'd1;
   localparam logic [2:0] ERR_CMD   = 3'd2;
   localparam logic [2:0] ERR_SHORT = 3'd3;
   localparam logic [2:0] ERR_TAIL  = 3'd4;
   localparam logic [2:0] ERR_LONG  = 3'd5;

   typedef enum logic [1:0] {IDLE, CMD, BODY, DROP} state_t;

endpackage

// File: rtl/frame_parser.sv
// Parses header/command/body/tail frames from a 64-bit valid/last stream and
// reports one registered command or error result per frame.
module frame_parser
   import frame_pkg::*;
#(
   parameter int unsigned MAX_BEATS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   input  logic        s_last,
   input  logic [63:0] s_data,
   output logic        cmd_valid,
   output logic [15:0] cmd_code,
   output logic [47:0] cmd_arg,
   output logic [7:0]  cmd_body_beats,
   output logic        err_valid,
   output logic [2:0]  err_code,
   output logic [15:0] frame_cnt,
   output logic [15:0] err_cnt
);

   state_t      state_q, state_d;
   logic [7:0]  beats_q, beats_d;
   logic [15:0] code_sh_q;
   logic        ok_fire, err_fire;
   logic [2:0]  err_sel;

   always_comb begin
      state_d  = state_q;
      beats_d  = beats_q;
      ok_fire  = 1'b0;
      err_fire = 1'b0;
      err_sel  = ERR_HDR;
      if (s_valid) begin
         beats_d = beats_q + 8'd1;
         unique case (state_q)
            IDLE: begin
               beats_d = 8'd1;
               if (s_data == HDR_WORD) begin
                  if (s_last) begin
                     err_fire = 1'b1;
                     err_sel  = ERR_SHORT;
                  end else begin
                     state_d = CMD;
                  end
               end else begin
                  err_fire = 1'b1;
                  err_sel  = ERR_HDR;
                  state_d  = s_last ? IDLE : DROP;
               end
            end
            CMD: begin
               if (s_data[63:16] != CMD_TAG) begin
                  err_fire = 1'b1;
                  err_sel  = ERR_CMD;
                  state_d  = s_last ? IDLE : DROP;
               end else if (s_last) begin
                  err_fire = 1'b1;
                  err_sel  = ERR_SHORT;
                  state_d  = IDLE;
               end else begin
                  state_d = BODY;
               end
            end
            BODY: begin
               if (s_last) begin
                  state_d = IDLE;
                  if (s_data[15:0] == TAIL_TAG) begin
                     ok_fire = 1'b1;
                  end else begin
                     err_fire = 1'b1;
                     err_sel  = ERR_TAIL;
                  end
               end else if (beats_d == 8'(MAX_BEATS)) begin
                  err_fire = 1'b1;
                  err_sel  = ERR_LONG;
                  state_d  = DROP;
               end
            end
            DROP: begin
               if (s_last) state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         beats_q        <= 8'd0;
         code_sh_q      <= 16'd0;
         cmd_valid      <= 1'b0;
         cmd_code       <= 16'd0;
         cmd_arg        <= 48'd0;
         cmd_body_beats <= 8'd0;
         err_valid      <= 1'b0;
         err_code       <= 3'd0;
         frame_cnt      <= 16'd0;
         err_cnt        <= 16'd0;
      end else begin
         state_q   <= state_d;
         beats_q   <= beats_d;
         cmd_valid <= ok_fire;
         err_valid <= err_fire;
         if (s_valid && state_q == CMD && state_d == BODY) code_sh_q <= s_data[15:0];
         if (ok_fire) begin
            cmd_code       <= code_sh_q;
            cmd_arg        <= s_data[63:16];
            // beats_q still holds header + command + body beats seen so far
            cmd_body_beats <= beats_q - 8'd2;
            frame_cnt      <= frame_cnt + 16'd1;
         end
         if (err_fire) begin
            err_code <= err_sel;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_frame_parser.sv
// Directed-vector bench for frame_parser with a result scoreboard.
module tb_frame_parser;

   localparam logic [63:0] HDR = 64'hFF00_5A5A_55AA_0F0F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid, s_last;
   logic [63:0] s_data;
   logic        cmd_valid, err_valid;
   logic [15:0] cmd_code, frame_cnt, err_cnt;
   logic [47:0] cmd_arg;
   logic [7:0]  cmd_body_beats;
   logic [2:0]  err_code;

   frame_parser #(.MAX_BEATS(16)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
      .cmd_body_beats(cmd_body_beats), .err_valid(err_valid), .err_code(err_code),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_cmd;
      logic [2:0]  ecode;
      logic [15:0] code;
      logic [47:0] arg;
      logic [7:0]  body;
      logic [15:0] fcnt;
      logic [15:0] ecnt;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] m_code, m_fcnt, m_ecnt;
   logic [47:0] m_arg;
   logic [7:0]  m_body;
   logic [2:0]  m_ecode;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_code = '0; m_arg = '0; m_body = '0; m_fcnt = '0; m_ecnt = '0; m_ecode = '0;
   endtask

   task automatic push(input logic is_cmd);
      exp_t e;
      e = '{is_cmd: is_cmd, ecode: m_ecode, code: m_code, arg: m_arg, body: m_body,
            fcnt: m_fcnt, ecnt: m_ecnt};
      sb.push_back(e);
   endtask

   task automatic push_ok(input logic [15:0] c, input logic [47:0] a, input logic [7:0] b);
      m_code = c; m_arg = a; m_body = b; m_fcnt = m_fcnt + 16'd1;
      push(1'b1);
   endtask

   task automatic push_err(input logic [2:0] ec);
      m_ecode = ec;
      if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
      push(1'b0);
   endtask

   task automatic beat(input logic v, input logic l, input logic [63:0] d);
      @(negedge clk);
      s_valid = v; s_last = l; s_data = d;
   endtask

   task automatic drain();
      beat(1'b0, 1'b0, 64'd0);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: pop and compare whenever a result pulse is presented.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (cmd_valid || err_valid)) begin
         check("mutex", 64'(cmd_valid & err_valid), 64'd0);
         if (sb.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("kind", 64'(cmd_valid), 64'(e.is_cmd));
            check("err_code", 64'(err_code), 64'(e.ecode));
            check("cmd_code", 64'(cmd_code), 64'(e.code));
            check("cmd_arg", 64'(cmd_arg), 64'(e.arg));
            check("body_beats", 64'(cmd_body_beats), 64'(e.body));
            check("frame_cnt", 64'(frame_cnt), 64'(e.fcnt));
            check("err_cnt", 64'(err_cnt), 64'(e.ecnt));
         end
      end
   end

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_err_valid", 64'(err_valid), 64'd0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      check("rst_cmd_arg", 64'(cmd_arg), 64'd0);

      // Frame 1 with an idle gap, frame 2 back-to-back
      beat(1, 0, HDR);
      beat(0, 0, 64'hDEAD_BEEF_DEAD_BEEF);
      beat(1, 0, 64'hBCBC_4400_0004_0000);
      beat(1, 1, 64'h0001_0000_0000_FCFC); push_ok(16'h0000, 48'h0001_0000_0000, 8'd0);
      beat(1, 0, HDR);
      beat(1, 0, 64'hBCBC_4400_0004_AAAA);
      beat(1, 1, 64'hBBBB_CCCC_DDDD_FCFC); push_ok(16'hAAAA, 48'hBBBB_CCCC_DDDD, 8'd0);
      // Bad tail after two body beats
      beat(1, 0, HDR);
      beat(1, 0, 64'hBCBC_4400_0004_1111);
      beat(1, 0, 64'h7777_8888_9999_AAAA);
      beat(1, 0, 64'h7777_8888_9999_AAAA);
      beat(1, 1, 64'h5555_6666_7777_1234); push_err(3'd4);
      // Good frame with two body beats and a gap inside the body
      beat(1, 0, HDR);
      beat(1, 0, 64'hBCBC_4400_0004_0042);
      beat(1, 0, 64'h1111_1111_1111_1111);
      beat(0, 1, 64'h0000_0000_0000_FCFC);
      beat(1, 0, 64'h2222_2222_2222_2222);
      beat(1, 1, 64'h0123_4567_89AB_FCFC); push_ok(16'h0042, 48'h0123_4567_89AB, 8'd2);
      // Bad header, dropped beats include a header word
      beat(1, 0, 64'h1111_2222_3333_4444); push_err(3'd1);
      beat(1, 0, HDR);
      beat(1, 0, 64'hBCBC_4400_0004_0000);
      beat(1, 0, 64'h0000_0000_0000_0000);
      beat(1, 1, 64'h0000_0000_0000_FCFC);
      // Short frames and bad command tag
      beat(1, 0, HDR);
      beat(1, 1, 64'hBCBC_4400_0004_5555); push_err(3'd3);
      beat(1, 1, HDR);                     push_err(3'd3);
      beat(1, 0, HDR);
      beat(1, 0, 64'hBCBC_4400_0005_5555); push_err(3'd2);
      beat(1, 1, 64'h0000_0000_0000_FCFC);
      drain();
      // Overlong: 16th beat without last
      beat(1, 0, HDR);
      beat(1, 0, 64'hBCBC_4400_0004_7777);
      for (int i = 0; i < 13; i++) beat(1, 0, 64'(i));
      beat(1, 0, 64'h0000_0000_0000_FCFC); push_err(3'd5);
      beat(1, 0, 64'h0000_0000_0000_0000);
      beat(1, 1, 64'h0000_0000_0000_FCFC);
      beat(1, 0, HDR);
      beat(1, 0, 64'hBCBC_4400_0004_BEEF);
      beat(1, 0, 64'h9999_9999_9999_9999);
      beat(1, 1, 64'hCAFE_F00D_1234_FCFC); push_ok(16'hBEEF, 48'hCAFE_F00D_1234, 8'd1);
      drain();
      check("pre_rst_frame_cnt", 64'(frame_cnt), 64'd4);
      check("pre_rst_err_cnt", 64'(err_cnt), 64'd6);

      // Reset mid-frame abandons it
      beat(1, 0, HDR);
      beat(1, 0, 64'hBCBC_4400_0004_3333);
      @(negedge clk);
      rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("post_rst_err_cnt", 64'(err_cnt), 64'd0);
      check("post_rst_cmd_code", 64'(cmd_code), 64'd0);
      check("post_rst_err_code", 64'(err_code), 64'd0);
      beat(1, 1, 64'h0001_0000_0000_FCFC); push_err(3'd1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
